// File: rtl/cavlc_pkg.sv
// Shared types and helpers for the CAVLC block controller.
// Scan-order index helpers map 4x4 luma indices to (x,y) block positions.
package cavlc_pkg;

    typedef enum logic [1:0] {
        BT_LUMA,
        BT_CDC420,
        BT_CDC422,
        BT_EXT
    } blk_type_e;

    typedef enum logic [2:0] {
        IDLE,
        NC_CALC,
        TOKEN,
        LATCH,
        RES_WAIT,
        DONE
    } state_e;

    localparam logic [4:0] NC_CDC420 = 5'b11111;
    localparam logic [4:0] NC_CDC422 = 5'b11110;

    function automatic logic [1:0] BLK_X(input logic [3:0] idx);
        return {idx[2], idx[0]};
    endfunction

    function automatic logic [1:0] BLK_Y(input logic [3:0] idx);
        return {idx[3], idx[1]};
    endfunction

    function automatic logic [3:0] BLK_IDX(input logic [1:0] x,
                                           input logic [1:0] y);
        return {y[1], x[1], y[0], x[0]};
    endfunction

endpackage

// File: rtl/cavlc_nc_calc.sv
// Luma nC predictor: picks left/top neighbour TotalCoeff and averages them.
// Neighbours inside the current MB come from the TC table and are always available.
module cavlc_nc_calc
    import cavlc_pkg::*;
#(
    parameter int TC_W = 5
) (
    input  logic [15:0][TC_W-1:0] tbl,
    input  logic [3:0]            idx,
    input  logic                  left_avail,
    input  logic [4*TC_W-1:0]     left_tc,
    input  logic                  top_avail,
    input  logic [4*TC_W-1:0]     top_tc,
    output logic [TC_W-1:0]       nc
);

    logic [1:0]      x;
    logic [1:0]      y;
    logic            a_av;
    logic            b_av;
    logic [TC_W-1:0] na;
    logic [TC_W-1:0] nb;
    logic [TC_W:0]   sum;

    always_comb begin
        x    = BLK_X(idx);
        y    = BLK_Y(idx);
        a_av = (x != 2'd0) || left_avail;
        b_av = (y != 2'd0) || top_avail;
        na   = (x != 2'd0) ? tbl[BLK_IDX(x - 2'd1, y)]
                           : left_tc[y*TC_W +: TC_W];
        nb   = (y != 2'd0) ? tbl[BLK_IDX(x, y - 2'd1)]
                           : top_tc[x*TC_W +: TC_W];
        sum  = {1'b0, na} + {1'b0, nb} + (TC_W+1)'(1);
        unique case ({a_av, b_av})
            2'b11:   nc = sum[TC_W:1];
            2'b10:   nc = na;
            2'b01:   nc = nb;
            default: nc = '0;
        endcase
    end

endmodule

// File: rtl/cavlc_block_ctrl.sv
// Per-block CAVLC sequencer: nC derivation, coeff-token step, residual hand-off.
// Holds the current MB's luma TotalCoeff table for intra-MB nC prediction.
module cavlc_block_ctrl
    import cavlc_pkg::*;
#(
    parameter int TC_W        = 5,
    parameter bit ERR_ZERO_SH = 1'b1
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              MbStart,
    input  logic              BlkStart,
    output logic              BlkReady,
    input  logic [1:0]        BlkType,
    input  logic [3:0]        BlkIdx,
    input  logic [TC_W-1:0]   ExtNc,
    input  logic              LeftAvail,
    input  logic [4*TC_W-1:0] LeftMbTc,
    input  logic              TopAvail,
    input  logic [4*TC_W-1:0] TopMbTc,
    input  logic              BitsValid,
    output logic [TC_W-1:0]   NC,
    output logic              TokEnable,
    input  logic [4:0]        NumShift,
    input  logic [TC_W-1:0]   TotalCoeff,
    input  logic [1:0]        TrailingOnes,
    output logic              ShiftEn,
    output logic [4:0]        ShiftAmt,
    output logic              ResStart,
    output logic [TC_W-1:0]   ResTc,
    output logic [1:0]        ResT1,
    input  logic              ResDone,
    output logic              BlkDone,
    output logic [TC_W-1:0]   BlkTc,
    output logic              Err
);

    state_e                 state_q, state_d;
    blk_type_e              type_q, type_d;
    logic [3:0]             idx_q, idx_d;
    logic [TC_W-1:0]        ext_q, ext_d;
    logic [15:0][TC_W-1:0]  tbl_q, tbl_d;
    logic [TC_W-1:0]        nc_q, nc_d;
    logic [TC_W-1:0]        res_tc_q, res_tc_d;
    logic [1:0]             res_t1_q, res_t1_d;
    logic [TC_W-1:0]        blk_tc_q, blk_tc_d;
    logic                   err_q, err_d;
    logic                   res_start_q, res_start_d;
    logic                   blk_done_q, blk_done_d;
    logic                   tok_en;
    logic                   shift_en;
    logic [TC_W-1:0]        nc_luma;

    cavlc_nc_calc #(.TC_W(TC_W)) u_nc_calc (
        .tbl        (tbl_q),
        .idx        (idx_q),
        .left_avail (LeftAvail),
        .left_tc    (LeftMbTc),
        .top_avail  (TopAvail),
        .top_tc     (TopMbTc),
        .nc         (nc_luma)
    );

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        idx_d       = idx_q;
        ext_d       = ext_q;
        tbl_d       = tbl_q;
        nc_d        = nc_q;
        res_tc_d    = res_tc_q;
        res_t1_d    = res_t1_q;
        blk_tc_d    = blk_tc_q;
        err_d       = err_q;
        res_start_d = 1'b0;
        blk_done_d  = 1'b0;
        tok_en      = 1'b0;
        shift_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MbStart) begin
                    tbl_d = '0;
                    err_d = 1'b0;
                end
                if (BlkStart) begin
                    type_d  = blk_type_e'(BlkType);
                    idx_d   = BlkIdx;
                    ext_d   = ExtNc;
                    state_d = NC_CALC;
                end
            end
            NC_CALC: begin
                unique case (type_q)
                    BT_LUMA:   nc_d = nc_luma;
                    BT_CDC420: nc_d = NC_CDC420;
                    BT_CDC422: nc_d = NC_CDC422;
                    default:   nc_d = ext_q;
                endcase
                state_d = TOKEN;
            end
            TOKEN: begin
                if (BitsValid) begin
                    tok_en = 1'b1;
                    // A zero-length code cannot be valid; skip the residual path.
                    if (ERR_ZERO_SH && NumShift == 5'd0) begin
                        err_d      = 1'b1;
                        blk_done_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        shift_en = 1'b1;
                        state_d  = LATCH;
                    end
                end
            end
            LATCH: begin
                res_tc_d = TotalCoeff;
                res_t1_d = TrailingOnes;
                blk_tc_d = TotalCoeff;
                if (type_q == BT_LUMA) tbl_d[idx_q] = TotalCoeff;
                if (TotalCoeff == '0) begin
                    blk_done_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    res_start_d = 1'b1;
                    state_d     = RES_WAIT;
                end
            end
            RES_WAIT: begin
                if (ResDone) begin
                    blk_done_d = 1'b1;
                    state_d    = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            type_q      <= BT_LUMA;
            idx_q       <= '0;
            ext_q       <= '0;
            tbl_q       <= '0;
            nc_q        <= '0;
            res_tc_q    <= '0;
            res_t1_q    <= '0;
            blk_tc_q    <= '0;
            err_q       <= 1'b0;
            res_start_q <= 1'b0;
            blk_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            idx_q       <= idx_d;
            ext_q       <= ext_d;
            tbl_q       <= tbl_d;
            nc_q        <= nc_d;
            res_tc_q    <= res_tc_d;
            res_t1_q    <= res_t1_d;
            blk_tc_q    <= blk_tc_d;
            err_q       <= err_d;
            res_start_q <= res_start_d;
            blk_done_q  <= blk_done_d;
        end
    end

    assign BlkReady  = (state_q == IDLE);
    assign NC        = nc_q;
    assign TokEnable = tok_en;
    assign ShiftEn   = shift_en;
    assign ShiftAmt  = shift_en ? NumShift : 5'd0;
    assign ResStart  = res_start_q;
    assign ResTc     = res_tc_q;
    assign ResT1     = res_t1_q;
    assign BlkDone   = blk_done_q;
    assign BlkTc     = blk_tc_q;
    assign Err       = err_q;

endmodule
